// File: rtl/ggt_pkg.sv
// Shared definitions for the subtractive-Euclid GCD engine.
package ggt_pkg;

    localparam int unsigned GGT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

endpackage

// File: rtl/ggt_datapath.sv
// Operand registers, comparator and subtractor for the GCD engine.
module ggt_datapath
    import ggt_pkg::*;
#(
    parameter int unsigned WIDTH = GGT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    output logic             o_done_cond,
    output logic [WIDTH-1:0] o_result
);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_eq;
    logic             w_a_gt_b;

    assign w_a_zero = (r_a == '0);
    assign w_b_zero = (r_b == '0);
    assign w_eq     = (r_a == r_b);
    assign w_a_gt_b = (r_a > r_b);

    assign o_done_cond = w_a_zero | w_b_zero | w_eq;
    // a zero operand yields the other one; otherwise both equal, or B is zero
    assign o_result    = w_a_zero ? r_b : r_a;

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_a <= '0;
            r_b <= '0;
        end else if (i_load) begin
            r_a <= i_opa;
            r_b <= i_opb;
        end else if (i_step) begin
            if (w_a_gt_b) begin
                r_a <= r_a - r_b;
            end else begin
                r_b <= r_b - r_a;
            end
        end
    end

endmodule

// File: rtl/ggt_euclid.sv
// Iterative GCD engine: start strobe in, level-held valid and result out.
module ggt_euclid
    import ggt_pkg::*;
#(
    parameter int unsigned WIDTH = GGT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] Zahl1_i,
    input  logic [WIDTH-1:0] Zahl2_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] ergebnis_o
);

    state_t           r_state;
    state_t           w_next;
    logic             w_load;
    logic             w_step;
    logic             w_finish;
    logic             w_done_cond;
    logic [WIDTH-1:0] w_result;
    logic             r_valid;
    logic [WIDTH-1:0] r_ergebnis;

    ggt_datapath #(
        .WIDTH(WIDTH)
    ) u_datapath (
        .clk        (clk),
        .rst_i      (rst_i),
        .i_load     (w_load),
        .i_step     (w_step),
        .i_opa      (Zahl1_i),
        .i_opb      (Zahl2_i),
        .o_done_cond(w_done_cond),
        .o_result   (w_result)
    );

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, DONE: if (start_i) w_next = CALC;
            CALC:       if (w_done_cond) w_next = DONE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load   = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        unique case (r_state)
            IDLE, DONE: w_load = start_i;
            CALC: begin
                w_step   = ~w_done_cond;
                w_finish = w_done_cond;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) begin
            r_valid    <= 1'b0;
            r_ergebnis <= '0;
        end else if (w_load) begin
            r_valid <= 1'b0;
        end else if (w_finish) begin
            r_valid    <= 1'b1;
            r_ergebnis <= w_result;
        end
    end

    assign valid_o    = r_valid;
    assign ergebnis_o = r_ergebnis;

endmodule

// File: tb/tb_ggt_euclid.sv
// Self-checking bench for ggt_euclid: directed table, long-job corners, random pairs.
module tb_ggt_euclid;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic [15:0] Zahl1_i;
    logic [15:0] Zahl2_i;
    logic        valid_o;
    logic [15:0] ergebnis_o;

    int checks = 0;
    int errors = 0;
    logic [15:0] last_g;
    bit          have_last;

    always #5 clk = ~clk;

    ggt_euclid #(
        .WIDTH(16)
    ) dut (
        .clk       (clk),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .Zahl1_i   (Zahl1_i),
        .Zahl2_i   (Zahl2_i),
        .valid_o   (valid_o),
        .ergebnis_o(ergebnis_o)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        int          lat;
    } vec_t;

    vec_t tbl[10];

    function automatic int unsigned ref_gcd(input int unsigned a, input int unsigned b);
        int unsigned t;
        while (b != 0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    // Subtraction count from quotients: a final exact division stops one step early.
    function automatic int unsigned ref_k(input int unsigned a, input int unsigned b);
        int unsigned hi, lo, q, r, k;
        if (a == 0 || b == 0) return 0;
        hi = (a > b) ? a : b;
        lo = (a > b) ? b : a;
        k  = 0;
        forever begin
            q = hi / lo;
            r = hi % lo;
            if (r == 0) begin
                k += q - 1;
                break;
            end
            k += q;
            hi = lo;
            lo = r;
        end
        return k;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_job(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_g, input int exp_lat);
        int n;
        bit seen;
        @(negedge clk);
        start_i = 1'b1;
        Zahl1_i = a;
        Zahl2_i = b;
        @(posedge clk);
        #1;
        chk({tag, " valid_low_after_start"}, valid_o, 0);
        if (have_last) chk({tag, " result_held_in_calc"}, ergebnis_o, last_g);
        start_i = 1'b0;
        Zahl1_i = 16'($urandom);
        Zahl2_i = 16'($urandom);
        n    = 0;
        seen = 1'b0;
        while (!seen && n < exp_lat + 20) begin
            @(posedge clk);
            #1;
            n++;
            seen = valid_o;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: got no valid after %0d edges expected edge %0d", tag, n, exp_lat);
        end else begin
            chk({tag, " latency"}, n, exp_lat);
            chk({tag, " result"}, ergebnis_o, exp_g);
        end
        last_g    = exp_g;
        have_last = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk({tag, " valid_held"}, valid_o, 1);
        chk({tag, " result_held"}, ergebnis_o, exp_g);
    endtask

    initial begin
        int n;
        bit seen;
        logic [15:0] ra, rb;

        tbl[0] = '{16'd24255, 16'd12540, 16'd165, 21};
        tbl[1] = '{16'd48,    16'd18,    16'd6,   5};
        tbl[2] = '{16'd12,    16'd12,    16'd12,  1};
        tbl[3] = '{16'd0,     16'd0,     16'd0,   1};
        tbl[4] = '{16'd0,     16'd7,     16'd7,   1};
        tbl[5] = '{16'd9,     16'd0,     16'd9,   1};
        tbl[6] = '{16'd100,   16'd75,    16'd25,  4};
        tbl[7] = '{16'd8,     16'd12,    16'd4,   3};
        tbl[8] = '{16'd7,     16'd13,    16'd1,   8};
        tbl[9] = '{16'd1,     16'd1,     16'd1,   1};

        have_last = 1'b0;
        last_g    = '0;
        rst_i     = 1'b1;
        start_i   = 1'b0;
        Zahl1_i   = '0;
        Zahl2_i   = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset valid", valid_o, 0);
        chk("reset result", ergebnis_o, 0);
        @(negedge clk);
        rst_i = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_job($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].g, tbl[i].lat);
        end

        // Worst-case job, with a stray start pulse mid-calculation that must be ignored.
        @(negedge clk);
        start_i = 1'b1;
        Zahl1_i = 16'd65535;
        Zahl2_i = 16'd1;
        @(posedge clk);
        #1;
        chk("long valid_low_after_start", valid_o, 0);
        start_i = 1'b0;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 70000) begin
            @(posedge clk);
            #1;
            n++;
            seen = valid_o;
            if (n == 100) begin
                start_i = 1'b1;
                Zahl1_i = 16'd8;
                Zahl2_i = 16'd12;
            end else begin
                start_i = 1'b0;
            end
        end
        start_i = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL long timeout: got no valid after %0d edges expected edge 65535", n);
        end else begin
            chk("long latency", n, 65535);
            chk("long result", ergebnis_o, 1);
        end
        last_g    = 16'd1;
        have_last = 1'b1;
        run_job("after_long", 16'd8, 16'd12, 16'd4, 3);

        // Asynchronous reset in the middle of a long calculation.
        @(negedge clk);
        start_i = 1'b1;
        Zahl1_i = 16'd65535;
        Zahl2_i = 16'd1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        repeat (500) @(posedge clk);
        #1;
        chk("midcalc valid_before_reset", valid_o, 0);
        chk("midcalc result_before_reset", ergebnis_o, 4);
        #1;
        rst_i = 1'b1;
        #1;
        chk("async_reset valid", valid_o, 0);
        chk("async_reset result", ergebnis_o, 0);
        @(negedge clk);
        rst_i     = 1'b0;
        have_last = 1'b0;
        run_job("after_reset", 16'd100, 16'd75, 16'd25, 4);

        for (int i = 0; i < 30; i++) begin
            ra = 16'($urandom_range(0, 255));
            rb = 16'($urandom_range(0, 255));
            run_job($sformatf("rnd%0d(%0d,%0d)", i, ra, rb), ra, rb,
                    16'(ref_gcd(ra, rb)), int'(ref_k(ra, rb)) + 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
